// File: rtl/if_id_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_if
// Purpose : Bundles the fetch-side inputs and the IF/ID outputs of
//           if_id_stage so the stage connects through one port.
// Signals :
//   start_i          start strobe (same one the PC register sees)
//   hd_i             hazard stall, 1 = hold IF/ID contents
//   flush_i          taken branch/jump resolved in ID, squash fetch
//   pc_i / instr_i   current PC and the instruction memory data for it
//   branch_i/_target_i, jump_i/_target_i   redirect requests from ID
//   next_pc_o        next PC for the PC register
//   pc_o, pc_plus4_o, instr_o, valid_o     IF/ID register contents
//   stall_cnt_o, flush_cnt_o               performance counters
// Modports: master = fetch/ID side driving the stage, slave = the stage.
// ---------------------------------------------------------------------------
interface if_id_stage_if;
    logic        start_i;
    logic        hd_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] next_pc_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        output start_i, hd_i, flush_i, pc_i, instr_i,
               branch_i, branch_target_i, jump_i, jump_target_i,
        input  next_pc_o, pc_o, pc_plus4_o, instr_o, valid_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, hd_i, flush_i, pc_i, instr_i,
               branch_i, branch_target_i, jump_i, jump_target_i,
        output next_pc_o, pc_o, pc_plus4_o, instr_o, valid_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Purpose : IF/ID pipeline register of the 5-stage pipeline. Latches
//           {PC, PC+PC_STEP, instruction, valid} with flush > stall > load
//           priority, and computes the next PC (jump > branch > sequential).
//           A start-up FSM (IDLE/RUN) keeps bubbles in IF/ID until start_i.
// Ports   :
//   clk_i  rising-edge clock
//   rst_i  asynchronous reset, active-low
//   bus    if_id_stage_if.slave (see interface file for the signal list)
// Option  : define IF_ID_PERF_EN to build the saturating stall/flush
//           counters; otherwise stall_cnt_o/flush_cnt_o are tied to 0.
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_id_stage_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load_bubble;
    logic        w_capture;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_seq;

    logic [31:0] r_pc_p1;
    logic [31:0] r_pc_plus4_p1;
    logic [31:0] r_instr_p1;
    logic        r_vld_p1;

    assign w_pc_seq = bus.pc_i + PC_STEP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hold (stall) is the case where neither bubble nor capture is asserted.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_bubble = 1'b0;
        w_capture     = 1'b0;
        w_next_pc     = w_pc_seq;
        case (r_state)
            IDLE: begin
                // pc_i is undefined until start, so even the start edge bubbles
                w_load_bubble = 1'b1;
                if (bus.start_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    w_load_bubble = 1'b1;
                end else if (!bus.hd_i) begin
                    w_capture = 1'b1;
                end
                if (bus.jump_i) begin
                    w_next_pc = bus.jump_target_i;
                end else if (bus.branch_i) begin
                    w_next_pc = bus.branch_target_i;
                end else if (bus.hd_i) begin
                    w_next_pc = bus.pc_i;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---- IF -> ID boundary ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc_p1       <= 32'h0;
            r_pc_plus4_p1 <= 32'h0;
            r_instr_p1    <= NOP_WORD;
            r_vld_p1      <= 1'b0;
        end else if (w_load_bubble) begin
            r_pc_p1       <= 32'h0;
            r_pc_plus4_p1 <= 32'h0;
            r_instr_p1    <= NOP_WORD;
            r_vld_p1      <= 1'b0;
        end else if (w_capture) begin
            r_pc_p1       <= bus.pc_i;
            r_pc_plus4_p1 <= w_pc_seq;
            r_instr_p1    <= bus.instr_i;
            r_vld_p1      <= 1'b1;
        end
    end

    assign bus.next_pc_o  = w_next_pc;
    assign bus.pc_o       = r_pc_p1;
    assign bus.pc_plus4_o = r_pc_plus4_p1;
    assign bus.instr_o    = r_instr_p1;
    assign bus.valid_o    = r_vld_p1;

`ifdef IF_ID_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else if (r_state == RUN) begin
            if (bus.flush_i) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else if (bus.hd_i) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
`else
    assign bus.stall_cnt_o = 32'h0;
    assign bus.flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    if_id_stage_if bus ();

    if_id_stage #(
        .NOP_WORD (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural view of the IF/ID register.
    bit          m_running;
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    logic [31:0] m_stalls, m_flushes;

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef IF_ID_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [31:0] exp_next_pc();
        if (!m_running)         return bus.pc_i + 32'd4;
        if (bus.jump_i)         return bus.jump_target_i;
        if (bus.branch_i)       return bus.branch_target_i;
        if (bus.hd_i)           return bus.pc_i;
        return bus.pc_i + 32'd4;
    endfunction

    task automatic model_reset();
        m_running = 0; m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_bubble();
        m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
    endtask

    // Advance one rising edge, updating the model from the inputs seen there.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_running) begin
            model_bubble();
            if (bus.start_i) m_running = 1;
        end else if (bus.flush_i) begin
            model_bubble();
            if (m_flushes != 32'hFFFF_FFFF) m_flushes++;
        end else if (bus.hd_i) begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls++;
        end else begin
            m_pc = bus.pc_i; m_pc4 = bus.pc_i + 32'd4;
            m_instr = bus.instr_i; m_valid = 1;
        end
        #1;
    endtask

    task automatic drive(input logic st, input logic hd, input logic fl,
                         input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        bus.start_i = st; bus.hd_i = hd; bus.flush_i = fl;
        bus.pc_i = pc; bus.instr_i = ins;
        bus.branch_i = 0; bus.jump_i = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.start_i = 0; bus.hd_i = 0; bus.flush_i = 0;
        bus.pc_i = 32'h100; bus.instr_i = 32'hDEAD_BEEF;
        bus.branch_i = 0; bus.branch_target_i = 0;
        bus.jump_i = 0; bus.jump_target_i = 0;
        model_reset();
        tick(); tick();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.pc_o !== 32'h0 ||
            bus.pc_plus4_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset: valid=%b instr=%h pc=%h pc4=%h, want 0/0/0/0",
                     bus.valid_o, bus.instr_o, bus.pc_o, bus.pc_plus4_o);
        end
        n_checks++;
        if (bus.stall_cnt_o !== 32'h0 || bus.flush_cnt_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_cnt: stall=%h flush=%h, want 0/0",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h40 + i * 4, 32'h1234_0000 + i);
            n_checks++;
            if (bus.next_pc_o !== bus.pc_i + 32'd4) begin
                n_errors++;
                $display("FAIL idle_next_pc: got %h want %h", bus.next_pc_o, bus.pc_i + 32'd4);
            end
            tick();
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.pc_o !== 32'h0) begin
                n_errors++;
                $display("FAIL idle_%0d: valid=%b instr=%h pc=%h, want 0/0/0",
                         i, bus.valid_o, bus.instr_o, bus.pc_o);
            end
        end
    endtask

    task automatic test_start_flow();
        logic [31:0] prog [3];
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003; prog[2] = 32'h0109_5020;
        drive(1, 0, 0, 32'h0, 32'hFFFF_FFFF);
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL start_edge_bubble: valid=%b instr=%h, want 0/0",
                     bus.valid_o, bus.instr_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, i * 4, prog[i]);
            tick();
            n_checks++;
            if (bus.pc_o !== i * 4 || bus.pc_plus4_o !== i * 4 + 4 ||
                bus.instr_o !== prog[i] || bus.valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL flow_%0d: pc=%h pc4=%h instr=%h valid=%b, want %h/%h/%h/1",
                         i, bus.pc_o, bus.pc_plus4_o, bus.instr_o, bus.valid_o,
                         i * 4, i * 4 + 4, prog[i]);
            end
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 32'h4, 32'h2009_0003);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 32'h8, 32'hA000_0000 + i);
            n_checks++;
            if (bus.next_pc_o !== 32'h8) begin
                n_errors++;
                $display("FAIL stall_next_pc: got %h want 00000008", bus.next_pc_o);
            end
            tick();
            n_checks++;
            if (bus.pc_o !== 32'h4 || bus.instr_o !== 32'h2009_0003 || bus.valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: pc=%h instr=%h valid=%b, want 00000004/20090003/1",
                         i, bus.pc_o, bus.instr_o, bus.valid_o);
            end
        end
        n_checks++;
        if (bus.stall_cnt_o !== exp_cnt(32'd2)) begin
            n_errors++;
            $display("FAIL stall_cnt: got %0d want %0d", bus.stall_cnt_o, exp_cnt(32'd2));
        end
        drive(0, 0, 0, 32'h8, 32'h0109_5020);
        tick();
        n_checks++;
        if (bus.pc_o !== 32'h8 || bus.instr_o !== 32'h0109_5020) begin
            n_errors++;
            $display("FAIL stall_release: pc=%h instr=%h, want 00000008/01095020",
                     bus.pc_o, bus.instr_o);
        end
    endtask

    task automatic test_flush_vs_stall();
        logic [31:0] s0, f0;
        s0 = m_stalls; f0 = m_flushes;
        drive(0, 1, 1, 32'hC, 32'h1111_2222);
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.pc_o !== 32'h0) begin
            n_errors++;
            $display("FAIL flush_bubble: valid=%b instr=%h pc=%h, want 0/0/0",
                     bus.valid_o, bus.instr_o, bus.pc_o);
        end
        n_checks++;
        if (bus.flush_cnt_o !== exp_cnt(f0 + 1) || bus.stall_cnt_o !== exp_cnt(s0)) begin
            n_errors++;
            $display("FAIL flush_cnt: flush=%0d stall=%0d, want %0d/%0d",
                     bus.flush_cnt_o, bus.stall_cnt_o, exp_cnt(f0 + 1), exp_cnt(s0));
        end
    endtask

    task automatic test_next_pc();
        drive(0, 0, 0, 32'h10, 32'h0);
        bus.branch_i = 1; bus.branch_target_i = 32'h40;
        bus.jump_i = 1; bus.jump_target_i = 32'h80;
        #1;
        n_checks++;
        if (bus.next_pc_o !== 32'h80) begin
            n_errors++; $display("FAIL npc_jump: got %h want 00000080", bus.next_pc_o);
        end
        bus.jump_i = 0; #1;
        n_checks++;
        if (bus.next_pc_o !== 32'h40) begin
            n_errors++; $display("FAIL npc_branch: got %h want 00000040", bus.next_pc_o);
        end
        bus.branch_i = 0; #1;
        n_checks++;
        if (bus.next_pc_o !== 32'h14) begin
            n_errors++; $display("FAIL npc_seq: got %h want 00000014", bus.next_pc_o);
        end
        bus.pc_i = 32'hFFFF_FFFC; #1;
        n_checks++;
        if (bus.next_pc_o !== 32'h0) begin
            n_errors++; $display("FAIL npc_wrap: got %h want 00000000", bus.next_pc_o);
        end
        tick();
        n_checks++;
        if (bus.pc_o !== 32'hFFFF_FFFC || bus.pc_plus4_o !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_latch: pc=%h pc4=%h, want fffffffc/00000000",
                     bus.pc_o, bus.pc_plus4_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start_i = ($urandom_range(0, 9) == 0);
            bus.hd_i    = ($urandom_range(0, 9) < 3);
            bus.flush_i = ($urandom_range(0, 9) < 2);
            bus.pc_i    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.instr_i = $urandom;
            // a stalled PC is never redirected at the same time
            bus.branch_i = !bus.hd_i && ($urandom_range(0, 3) == 0);
            bus.jump_i   = !bus.hd_i && ($urandom_range(0, 3) == 0);
            bus.branch_target_i = $urandom;
            bus.jump_target_i   = $urandom;
            #1;
            n_checks++;
            if (bus.next_pc_o !== exp_next_pc()) begin
                n_errors++;
                $display("FAIL rand_npc_%0d: got %h want %h", i, bus.next_pc_o, exp_next_pc());
            end
            tick();
            n_checks++;
            if (bus.pc_o !== m_pc || bus.pc_plus4_o !== m_pc4 || bus.instr_o !== m_instr ||
                bus.valid_o !== m_valid || bus.stall_cnt_o !== exp_cnt(m_stalls) ||
                bus.flush_cnt_o !== exp_cnt(m_flushes)) begin
                n_errors++;
                $display("FAIL rand_regs_%0d: got %h/%h/%h/%b/%0d/%0d want %h/%h/%h/%b/%0d/%0d",
                         i, bus.pc_o, bus.pc_plus4_o, bus.instr_o, bus.valid_o,
                         bus.stall_cnt_o, bus.flush_cnt_o, m_pc, m_pc4, m_instr, m_valid,
                         exp_cnt(m_stalls), exp_cnt(m_flushes));
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 32'h200, 32'hCAFE_F00D);
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b1) begin
            n_errors++; $display("FAIL areset_pre: valid=%b want 1", bus.valid_o);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h0 ||
            bus.stall_cnt_o !== 32'h0 || bus.flush_cnt_o !== 32'h0) begin
            n_errors++;
            $display("FAIL areset_now: valid=%b pc=%h instr=%h stall=%0d flush=%0d, want all 0",
                     bus.valid_o, bus.pc_o, bus.instr_o, bus.stall_cnt_o, bus.flush_cnt_o);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h300 + i * 4, $urandom);
            tick();
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0) begin
                n_errors++;
                $display("FAIL areset_idle_%0d: valid=%b instr=%h, want 0/0",
                         i, bus.valid_o, bus.instr_o);
            end
        end
        drive(1, 0, 0, 32'h0, 32'h5);
        tick();
        drive(0, 0, 0, 32'h0, 32'h2008_0005);
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h2008_0005) begin
            n_errors++;
            $display("FAIL areset_restart: valid=%b instr=%h, want 1/20080005",
                     bus.valid_o, bus.instr_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_idle();
        test_start_flow();
        test_stall();
        test_flush_vs_stall();
        test_next_pc();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch/decode boundary of the 5-stage pipeline. Sits directly downstream of the PC register and the instruction memory.
- Latches {PC, PC+4, instruction, valid} into the IF/ID pipeline register, honouring hazard stall and branch/jump flush.
- Also computes next-PC (sequential / branch / jump) that feeds the PC register's pc_i.
- Contains a start-up state machine so no garbage instruction enters decode before start_i.

Parameters:
- NOP_WORD, 32'h0000_0000, value driven on instr_o for bubbles (reset, idle, flush)
- PC_STEP, 4, byte increment for sequential fetch

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  same start strobe that the PC register sees
- hd_i  in  1  hazard-detection stall; 1 = hold IF/ID contents
- flush_i  in  1  taken branch/jump resolved in ID; 1 = squash fetched instruction
- pc_i  in  32  current PC from PC register
- instr_i  in  32  instruction memory read data for pc_i
- branch_i  in  1  take branch target this cycle
- branch_target_i  in  32  branch target from ID
- jump_i  in  1  take jump target this cycle
- jump_target_i  in  32  jump target from ID
- next_pc_o  out  32  next PC to PC register pc_i
- pc_o  out  32  IF/ID latched PC
- pc_plus4_o  out  32  IF/ID latched PC+PC_STEP
- instr_o  out  32  IF/ID latched instruction
- valid_o  out  1  IF/ID holds a real instruction
- stall_cnt_o  out  32  stall cycles (optional feature)
- flush_cnt_o  out  32  flush events (optional feature)

Behaviour:
- Reset (rst_i low, async): state=IDLE, pc_o=0, pc_plus4_o=0, instr_o=NOP_WORD, valid_o=0, counters=0. Deassertion takes effect on next rising edge.
- States: IDLE, RUN. IDLE->RUN on the edge where start_i=1. RUN is held until reset; start_i in RUN is ignored.
- IDLE: every edge loads bubble (pc_o=0, pc_plus4_o=0, instr_o=NOP_WORD, valid_o=0). The start edge itself also loads a bubble, because pc_i is not yet defined.
- RUN, per rising edge, priority flush > stall > normal:
  - flush_i=1: load bubble, regardless of hd_i.
  - hd_i=1, flush_i=0: hold all IF/ID registers unchanged.
  - Otherwise: pc_o<=pc_i, pc_plus4_o<=pc_i+PC_STEP, instr_o<=instr_i, valid_o<=1.
- Latency: instruction at pc_i appears on instr_o one edge later, unless stalled or flushed.
- next_pc_o is combinational, priority jump_i > branch_i > pc_i+PC_STEP.
  - When hd_i=1, next_pc_o=pc_i. The PC also holds, so this is harmless.
  - In IDLE, next_pc_o=pc_i+PC_STEP; the PC register overrides it with 0 on start.
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 = 32'h0000_0000, with no error flag.
- Reset mid-operation: all outputs return to reset values immediately and state returns to IDLE. A new start_i is required to run.

Optional Feature:
- Macro IF_ID_PERF_EN.
- Defined:
  - stall_cnt_o increments on each RUN edge with hd_i=1 and flush_i=0.
  - flush_cnt_o increments on each RUN edge with flush_i=1.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared only by reset.
- Undefined: both ports present and tied to 32'h0; no counter flops.

Test Plan:
- Reset then idle: rst_i low 2 cycles, release, start_i=0 for 3 cycles -> valid_o=0, instr_o=32'h0, pc_o=0 every cycle.
- Start and flow: start_i pulse, then pc_i=0,4,8 with instr_i=32'h20080005,32'h20090003,32'h01095020 -> the edge after each sees pc_o=0/4/8, pc_plus4_o=4/8/12, matching instr_o, valid_o=1.
- Stall: in RUN with pc_o=4 latched, hd_i=1 for 2 cycles while instr_i changes -> pc_o=4 and instr_o unchanged. next_pc_o=pc_i. Then hd_i=0 -> new capture.
- Flush vs stall: hd_i=1 and flush_i=1 same cycle -> next edge valid_o=0, instr_o=32'h0. flush_cnt_o +1 and stall_cnt_o unchanged when IF_ID_PERF_EN is defined.
- Next-PC priority: pc_i=32'h10, branch_i=1 (target 32'h40), jump_i=1 (target 32'h80) -> next_pc_o=32'h80. jump_i=0 -> 32'h40. Both 0 -> 32'h14. pc_i=32'hFFFF_FFFC, both 0 -> 32'h0.
- Async reset mid-run: drop rst_i between clock edges while valid_o=1 -> valid_o=0 immediately. After release, ignores instr_i until start_i is seen again.
